// File: rtl/sign_mag_disp_pkg.sv
// Shared types and constants for the sign-magnitude display stage.
// The FSM encoding, special segment patterns and BCD sizing live here.
package sign_mag_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } convStateT;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    // Magnitude is at most 127, so three BCD digits are always enough.
    localparam int BCD_DIGITS = 3;
    localparam int ITER_W     = 3;

    // One double-dabble iteration per magnitude bit.
    function automatic int bcdIterations(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/sign_mag_disp_bcd_to_sseg.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Bit 7 is the decimal point and stays dark; non-decimal codes blank the digit.
module bcd_to_sseg
    import sign_mag_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [7:0] o_sseg
);

    always_comb begin
        o_sseg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_sseg = 8'hC0;
            4'd1:    o_sseg = 8'hF9;
            4'd2:    o_sseg = 8'hA4;
            4'd3:    o_sseg = 8'hB0;
            4'd4:    o_sseg = 8'h99;
            4'd5:    o_sseg = 8'h92;
            4'd6:    o_sseg = 8'h82;
            4'd7:    o_sseg = 8'hF8;
            4'd8:    o_sseg = 8'h80;
            4'd9:    o_sseg = 8'h90;
            default: o_sseg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sign_mag_disp.sv
// Captures a sign-magnitude word, converts it to BCD with a sequential
// double-dabble FSM and scans it onto a 4-digit multiplexed display.
module sign_mag_disp
    import sign_mag_disp_pkg::*;
#(
    parameter int N            = 8,
    parameter int REFRESH_BITS = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sm_in,
    input  logic         load,
    output logic         busy,
    output logic         done_tick,
    output logic [3:0]   an,
    output logic [7:0]   sseg
);

    localparam int BCD_W = 4 * BCD_DIGITS;

    convStateT               r_state;
    logic                    r_busy;
    logic                    r_doneTick;
    logic                    r_sign;
    logic [N-2:0]            r_mag;
    logic [BCD_W-1:0]        r_bcd;
    logic [ITER_W-1:0]       r_iterCnt;
    logic [3:0]              r_dispHund;
    logic [3:0]              r_dispTens;
    logic [3:0]              r_dispOnes;
    logic                    r_dispSign;
    logic [REFRESH_BITS-1:0] r_refreshCnt;

    logic [BCD_W-1:0]        w_bcdAdj;
    logic [1:0]              w_digitSel;
    logic [3:0]              w_digitBcd;
    logic [3:0]              w_an;
    logic                    w_blank;
    logic                    w_signDigit;
    logic                    w_negative;
    logic [7:0]              w_segCode;
    logic [7:0]              w_sseg;

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        w_bcdAdj = r_bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_doneTick <= 1'b0;
            r_sign     <= 1'b0;
            r_mag      <= '0;
            r_bcd      <= '0;
            r_iterCnt  <= '0;
            r_dispHund <= 4'd0;
            r_dispTens <= 4'd0;
            r_dispOnes <= 4'd0;
            r_dispSign <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_doneTick <= 1'b0;
                    if (load) begin
                        r_sign    <= sm_in[N-1];
                        r_mag     <= sm_in[N-2:0];
                        r_bcd     <= '0;
                        r_iterCnt <= ITER_W'(bcdIterations(N));
                        r_busy    <= 1'b1;
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    {r_bcd, r_mag} <= {w_bcdAdj[BCD_W-2:0], r_mag, 1'b0};
                    r_iterCnt      <= r_iterCnt - 1'b1;
                    if (r_iterCnt == ITER_W'(1)) begin
                        r_doneTick <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_doneTick <= 1'b0;
                    r_busy     <= 1'b0;
                    r_dispHund <= r_bcd[11:8];
                    r_dispTens <= r_bcd[7:4];
                    r_dispOnes <= r_bcd[3:0];
                    r_dispSign <= r_sign;
                    r_state    <= IDLE;
                end
                default: begin
                    r_busy     <= 1'b0;
                    r_doneTick <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refreshCnt <= '0;
        end else begin
            r_refreshCnt <= r_refreshCnt + 1'b1;
        end
    end

    assign w_digitSel = r_refreshCnt[REFRESH_BITS-1 -: 2];
    assign w_negative = r_dispSign && ({r_dispHund, r_dispTens, r_dispOnes} != 12'd0);

    // Leading-zero suppression: tens blank only when hundreds is also zero.
    always_comb begin
        w_an        = 4'b1110;
        w_digitBcd  = r_dispOnes;
        w_blank     = 1'b0;
        w_signDigit = 1'b0;
        case (w_digitSel)
            2'd0: begin
                w_an       = 4'b1110;
                w_digitBcd = r_dispOnes;
            end
            2'd1: begin
                w_an       = 4'b1101;
                w_digitBcd = r_dispTens;
                w_blank    = (r_dispHund == 4'd0) && (r_dispTens == 4'd0);
            end
            2'd2: begin
                w_an       = 4'b1011;
                w_digitBcd = r_dispHund;
                w_blank    = (r_dispHund == 4'd0);
            end
            2'd3: begin
                w_an        = 4'b0111;
                w_signDigit = 1'b1;
            end
            default: begin
                w_an = 4'b1111;
            end
        endcase
    end

    bcd_to_sseg uDecoder (
        .i_bcd  (w_digitBcd),
        .o_sseg (w_segCode)
    );

    always_comb begin
        w_sseg = w_segCode;
        if (w_signDigit) begin
            w_sseg = w_negative ? SEG_MINUS : SEG_BLANK;
        end else if (w_blank) begin
            w_sseg = SEG_BLANK;
        end
    end

    assign busy      = r_busy;
    assign done_tick = r_doneTick;
    assign an        = w_an;
    assign sseg      = w_sseg;

endmodule

// File: tb/tb_sign_mag_disp.sv
// Self-checking bench for sign_mag_disp: latency, busy/ignore rules, reset abort,
// and the scanned display compared against a decimal reference model.
module tb_sign_mag_disp;

    localparam int N  = 8;
    localparam int RB = 4;
    localparam logic [7:0] SEG_CODES [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] sm_in = '0;
    logic         load = 1'b0;
    logic         busy;
    logic         done_tick;
    logic [3:0]   an;
    logic [7:0]   sseg;

    int checks   = 0;
    int failures = 0;
    int tbRefresh = 0;
    int modelMag  = 0;
    bit modelSign = 1'b0;

    sign_mag_disp #(.N(N), .REFRESH_BITS(RB)) dut (
        .clk       (clk),
        .reset     (reset),
        .sm_in     (sm_in),
        .load      (load),
        .busy      (busy),
        .done_tick (done_tick),
        .an        (an),
        .sseg      (sseg)
    );

    always #5 clk = ~clk;

    // Reference refresh counter: counts clocks since the last reset, modulo 2^RB.
    always @(posedge clk or posedge reset) begin
        if (reset) tbRefresh <= 0;
        else       tbRefresh <= (tbRefresh + 1) % (1 << RB);
    end

    function automatic logic [3:0] expAn(input int sel);
        return ~(4'b0001 << sel);
    endfunction

    function automatic logic [7:0] expSeg(input int sel, input int mag, input bit sgn);
        case (sel)
            0: return SEG_CODES[mag % 10];
            1: return (mag >= 10) ? SEG_CODES[(mag / 10) % 10] : 8'hFF;
            2: return (mag >= 100) ? SEG_CODES[mag / 100] : 8'hFF;
            default: return (sgn && mag != 0) ? 8'hBF : 8'hFF;
        endcase
    endfunction

    task automatic test_reset();
        int sel;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        if (done_tick !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %0b expected 0", done_tick); end
        if (an !== 4'b1110) begin failures++; $display("[TB] FAIL reset_an: got %b expected 1110", an); end
        if (sseg !== 8'hC0) begin failures++; $display("[TB] FAIL reset_sseg: got %h expected c0", sseg); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelMag  = 0;
        modelSign = 1'b0;
        for (int c = 0; c < 2 * (1 << RB); c++) begin
            @(negedge clk);
            sel = tbRefresh >> (RB - 2);
            checks += 2;
            if (an !== expAn(sel)) begin failures++; $display("[TB] FAIL reset_scan_an: got %b expected %b", an, expAn(sel)); end
            if (sseg !== expSeg(sel, 0, 1'b0)) begin failures++; $display("[TB] FAIL reset_scan_sseg digit%0d: got %h expected %h", sel, sseg, expSeg(sel, 0, 1'b0)); end
        end
    endtask

    task automatic test_load(input logic [N-1:0] val, input string name);
        int sel;
        @(negedge clk);
        sm_in = val;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (i > 1) @(negedge clk);
            checks += 2;
            if (busy !== 1'b1) begin failures++; $display("[TB] FAIL %s busy cycle%0d: got %0b expected 1", name, i, busy); end
            if (done_tick !== (i == N)) begin failures++; $display("[TB] FAIL %s done cycle%0d: got %0b expected %0b", name, i, done_tick, (i == N)); end
        end
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL %s busy_end: got %0b expected 0", name, busy); end
        if (done_tick !== 1'b0) begin failures++; $display("[TB] FAIL %s done_end: got %0b expected 0", name, done_tick); end
        modelMag  = int'(val[N-2:0]);
        modelSign = val[N-1];
        for (int c = 0; c < (1 << RB); c++) begin
            sel = tbRefresh >> (RB - 2);
            checks += 2;
            if (an !== expAn(sel)) begin failures++; $display("[TB] FAIL %s scan_an: got %b expected %b", name, an, expAn(sel)); end
            if (sseg !== expSeg(sel, modelMag, modelSign)) begin failures++; $display("[TB] FAIL %s digit%0d: got %h expected %h", name, sel, sseg, expSeg(sel, modelMag, modelSign)); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int doneCount = 0;
        int sel;
        @(negedge clk);
        sm_in = 8'h05;
        load  = 1'b1;
        @(negedge clk);
        sm_in = 8'h09;
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done_tick === 1'b1) doneCount++;
            @(negedge clk);
        end
        checks++;
        if (doneCount != 1) begin failures++; $display("[TB] FAIL b2b_done_count: got %0d expected 1", doneCount); end
        modelMag  = 5;
        modelSign = 1'b0;
        for (int c = 0; c < (1 << RB); c++) begin
            sel = tbRefresh >> (RB - 2);
            checks++;
            if (sseg !== expSeg(sel, modelMag, modelSign)) begin failures++; $display("[TB] FAIL b2b digit%0d: got %h expected %h", sel, sseg, expSeg(sel, modelMag, modelSign)); end
            @(negedge clk);
        end
    endtask

    task automatic test_held_load();
        int sel;
        bit expBusy;
        bit expDone;
        @(negedge clk);
        sm_in = 8'h03;
        load  = 1'b1;
        @(negedge clk);
        sm_in = 8'h8A;
        for (int i = 1; i <= 2 * N + 2; i++) begin
            if (i > 1) @(negedge clk);
            expBusy = !(i == N + 1 || i == 2 * N + 2);
            expDone = (i == N || i == 2 * N + 1);
            checks += 2;
            if (busy !== expBusy) begin failures++; $display("[TB] FAIL held busy cycle%0d: got %0b expected %0b", i, busy, expBusy); end
            if (done_tick !== expDone) begin failures++; $display("[TB] FAIL held done cycle%0d: got %0b expected %0b", i, done_tick, expDone); end
            if (i == N + 2) load = 1'b0;
        end
        modelMag  = 10;
        modelSign = 1'b1;
        for (int c = 0; c < (1 << RB); c++) begin
            sel = tbRefresh >> (RB - 2);
            checks++;
            if (sseg !== expSeg(sel, modelMag, modelSign)) begin failures++; $display("[TB] FAIL held digit%0d: got %h expected %h", sel, sseg, expSeg(sel, modelMag, modelSign)); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        int sel;
        int doneCount = 0;
        @(negedge clk);
        sm_in = 8'h65;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %0b expected 0", busy); end
        if (an !== 4'b1110) begin failures++; $display("[TB] FAIL abort_an: got %b expected 1110", an); end
        if (sseg !== 8'hC0) begin failures++; $display("[TB] FAIL abort_sseg: got %h expected c0", sseg); end
        @(negedge clk);
        reset = 1'b0;
        modelMag  = 0;
        modelSign = 1'b0;
        for (int c = 0; c < 2 * (1 << RB); c++) begin
            @(negedge clk);
            if (done_tick === 1'b1) doneCount++;
            sel = tbRefresh >> (RB - 2);
            checks++;
            if (sseg !== expSeg(sel, modelMag, modelSign)) begin failures++; $display("[TB] FAIL abort digit%0d: got %h expected %h", sel, sseg, expSeg(sel, modelMag, modelSign)); end
        end
        checks++;
        if (doneCount != 0) begin failures++; $display("[TB] FAIL abort_done_count: got %0d expected 0", doneCount); end
        test_load(8'h65, "reload_101");
    endtask

    task automatic test_random();
        logic [N-1:0] val;
        for (int k = 0; k < 12; k++) begin
            val = N'($urandom_range(0, (1 << N) - 1));
            test_load(val, "random");
        end
    endtask

    initial begin
        test_reset();
        test_load(8'h7F, "pos127");
        test_load(8'h8C, "neg12");
        test_load(8'h80, "negzero");
        test_back_to_back();
        test_held_load();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
